// File: rtl/rmii_pkg.sv
// Shared RMII definitions: receiver state encoding and framing constants.
package rmii_pkg;

    localparam int unsigned RMII_LEN_W     = 11;
    localparam logic [1:0]  RMII_PRE_DIBIT = 2'b01;
    localparam logic [7:0]  RMII_SFD_BYTE  = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_DROP
    } rmii_rx_state_t;

    // Dibit idx (0 = first on the wire) of the SFD byte; bytes travel MSB dibit first.
    function automatic logic [1:0] sfd_dibit(input logic [1:0] idx);
        logic [7:0] sfd;
        sfd = RMII_SFD_BYTE << {idx, 1'b0};
        return sfd[7:6];
    endfunction

endpackage

// File: rtl/rmii_receiver.sv
// RMII receive path: assembles MSB-first dibits into byte strobes with frame
// start/end/error markers. Build option RMII_RX_PREAMBLE_STRIP_EN: when defined,
// preamble and SFD are checked and stripped; otherwise every dibit seen while
// crs_dv is high is delivered as payload.
module rmii_receiver
    import rmii_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned PRE_MIN = 4
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic [1:0]            rx_d,
    input  logic                  crs_dv,
    output logic [7:0]            data_o,
    output logic                  valid_o,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic                  err_o,
    output logic [RMII_LEN_W-1:0] len_o
);

    localparam logic [RMII_LEN_W-1:0] MAX_LEN_C = RMII_LEN_W'(MAX_LEN);

    // Reject parameter values the counters cannot represent.
    if (PRE_MIN > 15 || MAX_LEN > 2047) begin : g_bad_param
        $error("rmii_receiver: PRE_MIN must be <= 15 and MAX_LEN <= 2047");
    end

    rmii_rx_state_t        state_q, state_d;
    logic [1:0]            dibit_cnt_q, dibit_cnt_d;
    logic [5:0]            shift_q, shift_d;
    logic [RMII_LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sof_q, sof_d;
    logic                  eof_q, eof_d;
    logic                  err_q, err_d;
    logic [RMII_LEN_W-1:0] len_q, len_d;
`ifdef RMII_RX_PREAMBLE_STRIP_EN
    localparam logic [3:0] PRE_MIN_C   = 4'(PRE_MIN);
    localparam logic [3:0] PRE_CNT_MAX = 4'd15;
    logic [3:0]            pre_cnt_q, pre_cnt_d;
`endif

    // Next-state, byte assembly and output strobe generation.
    always_comb begin
        state_d     = state_q;
        dibit_cnt_d = dibit_cnt_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        err_d       = 1'b0;
        len_d       = len_q;
`ifdef RMII_RX_PREAMBLE_STRIP_EN
        pre_cnt_d   = pre_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (crs_dv) begin
`ifdef RMII_RX_PREAMBLE_STRIP_EN
                    if (rx_d == RMII_PRE_DIBIT) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = ST_DROP;
                    end
`else
                    // First dibit of the burst is already payload.
                    state_d     = ST_DATA;
                    shift_d     = {shift_q[3:0], rx_d};
                    dibit_cnt_d = 2'd1;
                    byte_cnt_d  = '0;
`endif
                end
            end
`ifdef RMII_RX_PREAMBLE_STRIP_EN
            ST_PREAMBLE: begin
                if (!crs_dv) begin
                    state_d = ST_IDLE;
                end else if (rx_d == RMII_PRE_DIBIT) begin
                    if (pre_cnt_q != PRE_CNT_MAX) pre_cnt_d = pre_cnt_q + 4'd1;
                end else if (rx_d == sfd_dibit(2'd0) && pre_cnt_q >= PRE_MIN_C) begin
                    state_d     = ST_SFD;
                    dibit_cnt_d = 2'd1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_SFD: begin
                if (!crs_dv) begin
                    state_d = ST_IDLE;
                end else if (rx_d == sfd_dibit(dibit_cnt_q)) begin
                    if (dibit_cnt_q == 2'd3) begin
                        state_d     = ST_DATA;
                        dibit_cnt_d = 2'd0;
                        byte_cnt_d  = '0;
                    end else begin
                        dibit_cnt_d = dibit_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_DROP;
                end
            end
`endif
            ST_DATA: begin
                if (!crs_dv) begin
                    // A partial byte in flight marks the frame bad and is discarded.
                    eof_d       = 1'b1;
                    err_d       = (dibit_cnt_q != 2'd0);
                    len_d       = byte_cnt_q;
                    dibit_cnt_d = 2'd0;
                    state_d     = ST_IDLE;
                end else begin
                    shift_d     = {shift_q[3:0], rx_d};
                    dibit_cnt_d = dibit_cnt_q + 2'd1;
                    if (dibit_cnt_q == 2'd3) begin
                        if (byte_cnt_q >= MAX_LEN_C) begin
                            eof_d   = 1'b1;
                            err_d   = 1'b1;
                            len_d   = MAX_LEN_C;
                            state_d = ST_DROP;
                        end else begin
                            data_d     = {shift_q, rx_d};
                            valid_d    = 1'b1;
                            sof_d      = (byte_cnt_q == '0);
                            byte_cnt_d = byte_cnt_q + RMII_LEN_W'(1);
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!crs_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dibit_cnt_q <= 2'd0;
            shift_q     <= 6'd0;
            byte_cnt_q  <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= '0;
`ifdef RMII_RX_PREAMBLE_STRIP_EN
            pre_cnt_q   <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            dibit_cnt_q <= dibit_cnt_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            err_q       <= err_d;
            len_q       <= len_d;
`ifdef RMII_RX_PREAMBLE_STRIP_EN
            pre_cnt_q   <= pre_cnt_d;
`endif
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sof_o   = sof_q;
    assign eof_o   = eof_q;
    assign err_o   = err_q;
    assign len_o   = len_q;

endmodule

// File: tb/tb_rmii_receiver.sv
// Scoreboard bench for rmii_receiver: each burst's expected strobes are derived
// from the dibit list being driven and compared as the DUT emits them.
module tb_rmii_receiver;

    localparam int TB_PRE_MIN = 4;
`ifdef RMII_RX_PREAMBLE_STRIP_EN
    localparam int TB_MAX_LEN = 4;
`else
    localparam int TB_MAX_LEN = 12;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rx_d;
    logic        crs_dv;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        sof_o;
    logic        eof_o;
    logic        err_o;
    logic [10:0] len_o;

    rmii_receiver #(
        .MAX_LEN (TB_MAX_LEN),
        .PRE_MIN (TB_PRE_MIN)
    ) dut (
        .ref_clk (clk),
        .rst_n   (rst_n),
        .rx_d    (rx_d),
        .crs_dv  (crs_dv),
        .data_o  (data_o),
        .valid_o (valid_o),
        .sof_o   (sof_o),
        .eof_o   (eof_o),
        .err_o   (err_o),
        .len_o   (len_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_eof;
        logic [7:0] data;
        bit         sof;
        bit         err;
        int         len;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] stim[$];
    int         exp_last_len = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_pre(input int n);
        for (int i = 0; i < n; i++) stim.push_back(2'b01);
    endtask

    task automatic add_dibit(input logic [1:0] d);
        stim.push_back(d);
    endtask

    task automatic add_byte(input logic [7:0] b);
        stim.push_back(b[7:6]);
        stim.push_back(b[5:4]);
        stim.push_back(b[3:2]);
        stim.push_back(b[1:0]);
    endtask

    // Frame-level expectation for the burst in stim.
    task automatic push_expect(input bit with_eof);
        int   s;
        int   n;
        int   nb;
        int   rem;
        bit   ok;
        exp_t e;
        ok = 1'b1;
        s  = 0;
        n  = 0;
`ifdef RMII_RX_PREAMBLE_STRIP_EN
        while (n < stim.size() && stim[n] == 2'b01) n++;
        if (n == 0 || stim.size() < n + 4) ok = 1'b0;
        else if (stim[n] != 2'b11 || n < TB_PRE_MIN) ok = 1'b0;
        else if (stim[n+1] != 2'b01 || stim[n+2] != 2'b01 || stim[n+3] != 2'b01) ok = 1'b0;
        s = n + 4;
`endif
        if (ok) begin
            nb  = (stim.size() - s) / 4;
            rem = (stim.size() - s) % 4;
            for (int i = 0; i < nb && i < TB_MAX_LEN; i++) begin
                e.is_eof = 1'b0;
                e.data   = {stim[s+4*i], stim[s+4*i+1], stim[s+4*i+2], stim[s+4*i+3]};
                e.sof    = (i == 0);
                e.err    = 1'b0;
                e.len    = 0;
                sb.push_back(e);
            end
            e.is_eof = 1'b1;
            e.data   = 8'h00;
            e.sof    = 1'b0;
            if (nb > TB_MAX_LEN) begin
                e.err = 1'b1;
                e.len = TB_MAX_LEN;
                sb.push_back(e);
                exp_last_len = TB_MAX_LEN;
            end else if (with_eof) begin
                e.err = (rem != 0);
                e.len = nb;
                sb.push_back(e);
                exp_last_len = nb;
            end
        end
    endtask

    // Drive the burst in stim, then hold crs_dv low for gap cycles.
    task automatic drive(input bit with_eof, input int gap);
        push_expect(with_eof);
        foreach (stim[i]) begin
            @(negedge clk);
            crs_dv = 1'b1;
            rx_d   = stim[i];
        end
        if (with_eof) begin
            @(negedge clk);
            crs_dv = 1'b0;
            rx_d   = 2'b00;
            repeat (gap - 1) @(negedge clk);
        end
        stim.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data"},  32'(data_o),  32'h0);
        check_eq({tag, "_valid"}, 32'(valid_o), 32'h0);
        check_eq({tag, "_sof"},   32'(sof_o),   32'h0);
        check_eq({tag, "_eof"},   32'(eof_o),   32'h0);
        check_eq({tag, "_err"},   32'(err_o),   32'h0);
        check_eq({tag, "_len"},   32'(len_o),   32'h0);
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid_o && eof_o) check_eq("valid_eof_overlap", 32'(eof_o), 32'h0);
            if (valid_o || eof_o) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_strobe", 32'({valid_o, eof_o}), 32'h0);
                end else begin
                    e = sb.pop_front();
                    if (e.is_eof) begin
                        check_eq("eof",     32'(eof_o), 32'h1);
                        check_eq("eof_err", 32'(err_o), 32'(e.err));
                        check_eq("eof_len", 32'(len_o), 32'(e.len));
                    end else begin
                        check_eq("valid",    32'(valid_o), 32'h1);
                        check_eq("data",     32'(data_o),  32'(e.data));
                        check_eq("data_sof", 32'(sof_o),   32'(e.sof));
                    end
                end
            end
            if (sof_o && !valid_o) check_eq("stray_sof", 32'(sof_o), 32'h0);
            if (err_o && !eof_o)   check_eq("stray_err", 32'(err_o), 32'h0);
        end
    end

    initial begin
        rst_n  = 1'b0;
        crs_dv = 1'b0;
        rx_d   = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean frame
        add_pre(28); add_byte(8'hD5);
        add_byte(8'hA5); add_byte(8'h3C); add_byte(8'hFF);
        drive(1'b1, 4);

        // Short preamble, then a good frame
        add_pre(2); add_dibit(2'b11); add_byte(8'h11); add_byte(8'h22);
        drive(1'b1, 4);
        check_eq("len_hold", 32'(len_o), 32'(exp_last_len));
        add_pre(8); add_byte(8'hD5); add_byte(8'h5A); add_byte(8'h00);
        drive(1'b1, 4);

        // Corrupted SFD
        add_pre(8); add_dibit(2'b11); add_dibit(2'b01); add_dibit(2'b00); add_byte(8'h77);
        drive(1'b1, 4);

        // Truncated byte
        add_pre(28); add_byte(8'hD5); add_byte(8'h12);
        add_dibit(2'b10); add_dibit(2'b01);
        drive(1'b1, 4);

        // Exactly MAX_LEN bytes total is still clean
        add_pre(28); add_byte(8'hD5);
        add_byte(8'h01); add_byte(8'h80); add_byte(8'hC3); add_byte(8'h7E);
        drive(1'b1, 4);

        // Overflow
        add_pre(28); add_byte(8'hD5);
        for (int i = 0; i < 6; i++) add_byte(8'(8'h40 + i));
        drive(1'b1, 4);
        check_eq("len_after_ovf", 32'(len_o), 32'(TB_MAX_LEN));

        // Back-to-back with one idle cycle
        add_pre(28); add_byte(8'hD5); add_byte(8'hDE); add_byte(8'hAD);
        drive(1'b1, 1);
        add_pre(28); add_byte(8'hD5); add_byte(8'hBE); add_byte(8'hEF);
        drive(1'b1, 4);

        // Reset asserted mid-payload
        add_pre(28); add_byte(8'hD5); add_byte(8'h5A);
        add_dibit(2'b11); add_dibit(2'b00);
        drive(1'b0, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        crs_dv = 1'b0;
        rx_d   = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_pre(28); add_byte(8'hD5); add_byte(8'h96); add_byte(8'h69);
        drive(1'b1, 4);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check_eq("sb_drain", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rmii_receiver.md
# rmii_receiver

RMII receive path: samples 2-bit receive data on `ref_clk` while `crs_dv` is high, strips preamble/SFD and reassembles bytes, then presents them as one-cycle strobes to the MAC. It is the receive-side counterpart of the team's RMII transmitter. Dibit order matches that transmitter: bits [7:6] of each byte arrive first, and bits [1:0] arrive last.

## Interface
- `MAX_LEN`, default 1518: maximum payload bytes per frame, counted after SFD; exceeding it is an error.
- `PRE_MIN`, default 4: minimum consecutive preamble dibits (2'b01) required before SFD is accepted.
- `ref_clk` input 1: 50 MHz RMII reference clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_d` input 2: RMII receive dibit.
- `crs_dv` input 1: carrier sense / data valid.
- `data_o` output 8: assembled byte; valid when `valid_o`=1.
- `valid_o` output 1: one-cycle strobe per byte.
- `sof_o` output 1: high with `valid_o` on the first payload byte.
- `eof_o` output 1: one-cycle pulse at frame end.
- `err_o` output 1: high with `eof_o` when the frame was bad.
- `len_o` output 11: payload byte count of the last completed frame; updated with `eof_o`.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, DROP.
- IDLE:
  - `crs_dv`=1 and `rx_d`=2'b01 -> PREAMBLE, with the preamble counter set to 1.
  - `crs_dv`=1 with any other dibit -> DROP.
- PREAMBLE:
  - `rx_d`=2'b01: increment the counter, saturating at 15.
  - `rx_d`=2'b11 with counter >= `PRE_MIN` -> SFD. The SFD dibit index is set to 1.
  - Any other dibit, or 2'b11 too early -> DROP.
  - `crs_dv` low -> IDLE. No `eof_o` is produced, because no frame has started.
- SFD:
  - Expects three dibits of 2'b01, completing 0xD5.
  - All three match -> DATA, with the dibit counter set to 0.
  - Mismatch -> DROP.
  - `crs_dv` low -> IDLE. No `eof_o`.
- DATA:
  - The shift register accumulates dibits MSB-first: `shift <= {shift[5:0], rx_d}`.
  - On the 4th dibit, the byte is registered to `data_o` and `valid_o` pulses.
  - The byte counter increments; `sof_o` is high if the count was 0.
  - `crs_dv` low with the dibit counter = 0 -> clean end: `eof_o`=1, `err_o`=0, `len_o`=count, then IDLE.
  - `crs_dv` low mid-byte (dibit counter 1..3) -> `eof_o`=1, `err_o`=1. The partial byte is discarded, `len_o`=count of whole bytes, then IDLE.
  - Count would exceed `MAX_LEN` -> the byte is not emitted. `eof_o`=1, `err_o`=1, `len_o`=`MAX_LEN`, then DROP.
- DROP: ignores input until `crs_dv`=0, then IDLE. It never emits `valid_o`. `eof_o` appears only on the overflow entry described above.
- Byte counter width is 11 bits. It is cleared on entry to DATA and never wraps.
- `len_o` holds its value between frames.

## Timing
- Reset (asynchronous assert, synchronous-to-`ref_clk` release):
  - State IDLE.
  - `data_o`=8'h00; `valid_o`, `sof_o`, `eof_o`, `err_o` = 0.
  - `len_o`=0; all counters and the shift register cleared.
- `rx_d` and `crs_dv` are sampled on the rising edge of `ref_clk`.
- Byte latency: `valid_o` is high in the cycle after the edge that sampled the 4th dibit of a byte.
- Minimum spacing between `valid_o` pulses is 4 cycles. No backpressure exists; the consumer must accept every strobe.
- `eof_o` is high in the cycle after the edge that samples `crs_dv`=0. It never coincides with `valid_o`.
- `crs_dv` rising in the same cycle as the `eof_o` pulse is sampled as the first preamble dibit of a new frame.
- Reset asserted mid-frame: all outputs go to reset values immediately. No `eof_o` is generated for the aborted frame.

## Configuration
- Macro: `RMII_RX_PREAMBLE_STRIP_EN`.
- Defined: behaviour as above; preamble and SFD are checked and are not delivered.
- Undefined:
  - PREAMBLE and SFD states are compiled out, and IDLE goes directly to DATA when `crs_dv` rises.
  - Every dibit received while `crs_dv`=1 is assembled, including the preamble and the 0xD5 byte.
  - `sof_o` marks the first assembled byte.
  - `len_o` counts all bytes.
  - `PRE_MIN` is unused.

## Structure
- Shared package `rmii_pkg`:
  - state enum `rmii_rx_state_t`.
  - constants `RMII_PRE_DIBIT`=2'b01 and `RMII_SFD_BYTE`=8'hD5.
  - `RMII_LEN_W`=11.
- Single module; no sub-module. The dibit shift/assemble logic is small enough to stay inline.

## Test plan
- Clean frame:
  - Stimulus: 28 preamble dibits, 0xD5, bytes 0xA5, 0x3C, 0xFF, then `crs_dv` low.
  - Required: 3 `valid_o` pulses with `data_o` = A5, 3C, FF; `sof_o` with A5; `eof_o`=1 and `err_o`=0; `len_o`=3.
- Short preamble:
  - Stimulus: 2 preamble dibits, then 2'b11, then data.
  - Required: no `valid_o` and no `eof_o` until `crs_dv` falls; next good frame received normally.
- Truncated byte:
  - Stimulus: preamble, SFD, 0x12, then 2 dibits of the next byte, then `crs_dv` low.
  - Required: one `valid_o` (0x12); `eof_o` with `err_o`=1; `len_o`=1.
- Overflow:
  - Stimulus: `MAX_LEN`=4, frame of 6 bytes.
  - Required: 4 `valid_o` pulses; `eof_o`+`err_o` on the 5th byte boundary; `len_o`=4; nothing further until `crs_dv` low.
- Back-to-back:
  - Stimulus: `crs_dv` falls for exactly 1 cycle between two frames.
  - Required: both frames delivered; the second `sof_o` is correct.
- Reset:
  - Stimulus: `rst_n` pulsed low mid-DATA.
  - Required: all outputs 0 within the same cycle; no `eof_o`; the following frame is received cleanly.
